// File: rtl/hazard_pkg.sv
// Shared definitions for the RV32 pipeline hazard controller.
//   - forwarding select codes driven onto fwd_rs1_sel / fwd_rs2_sel
//   - multi-cycle EX FSM state encoding
//   - RV32 opcode constants the decoder uses to form ex_is_load / ex_is_mc
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    // M-extension register-register ops (mul/div family) are the multi-cycle ones.
    function automatic logic is_mc_op(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPC_OP) && (funct7 == FUNCT7_MEXT);
    endfunction

endpackage

// File: rtl/hazard_unit_mc_stall_fsm.sv
// Multi-cycle EX operation stall sequencer.
// Holds the pipeline front end while a mul/div occupies EX for MC_LAT cycles.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   ex_valid, ex_is_mc   EX holds a valid multi-cycle op
//   mem_stall            data-memory wait (higher priority than mc stall)
//   mc_stall             request to hold PC/IF-ID/ID-EX and bubble EX-MEM
//   state                current FSM state
module mc_stall_fsm
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 3
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      ex_valid,
    input  logic      ex_is_mc,
    input  logic      mem_stall,
    output logic      mc_stall,
    output mc_state_e state
);

    // Counter only needs to hold MC_LAT-2; keep at least one bit for MC_LAT<=2.
    localparam int            CW       = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (MC_LAT > 2) ? CW'(MC_LAT - 2) : '0;
    localparam logic          MC_EN    = (MC_LAT > 1);

    mc_state_e     state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mc_stall  = 1'b0;
        case (state)
            MC_IDLE: begin
                // A memory wait freezes EX, so the op is only started once memory releases.
                if (MC_EN && ex_valid && ex_is_mc && !mem_stall) begin
                    mc_stall  = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = (CNT_LOAD != '0) ? MC_BUSY : MC_DONE;
                end
            end
            MC_BUSY: begin
                mc_stall = 1'b1;
                cnt_nxt  = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_nxt = MC_DONE;
                end
            end
            MC_DONE: begin
                // The finished op is still sitting in EX; staying here keeps it
                // from being started a second time while memory holds the pipe.
                if (!mem_stall) begin
                    state_nxt = MC_IDLE;
                end
            end
            default: begin
                state_nxt = MC_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
// Produces per-stage stall/flush controls, EX operand forwarding selects and
// saturating perf counters.
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   id_rs1/rs2, id_rs1/rs2_used       ID source indices and use flags
//   ex_rs1/rs2, ex_rd, ex_*           EX sources, destination and op flags
//   ex_redirect                       EX resolved taken branch / JAL / JALR
//   mem_rd, mem_we                    MEM destination and write enable
//   mem_req, mem_ready                data-memory handshake
//   wb_rd, wb_we                      WB destination and write enable
//   stall_*                           hold the named pipeline register
//   flush_*                           load a bubble into the named register
//   fwd_rs1_sel, fwd_rs2_sel          00 regfile, 01 MEM, 10 WB
//   stall_cycles, redirect_cnt        saturating perf counters
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic              ex_is_mc,
    input  logic              ex_redirect,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              stall_idex,
    output logic              stall_exmem,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic              flush_memwb,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  redirect_cnt
);

    logic      mem_stall;
    logic      load_use;
    logic      mc_stall;
    logic      redirect_take;
    mc_state_e mc_state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // MEM is the younger producer, so it wins over WB. x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_we
    );
        if (m_we && (m_rd != '0) && (m_rd == rs)) return FWD_MEM;
        if (w_we && (w_rd != '0) && (w_rd == rs)) return FWD_WB;
        return FWD_RF;
    endfunction

    assign mem_stall = mem_req & ~mem_ready;

    assign load_use = ex_valid & ex_is_load & ex_we & (ex_rd != '0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));

    mc_stall_fsm #(
        .MC_LAT (MC_LAT)
    ) u_mc (
        .clk       (clk),
        .rstn      (rstn),
        .ex_valid  (ex_valid),
        .ex_is_mc  (ex_is_mc),
        .mem_stall (mem_stall),
        .mc_stall  (mc_stall),
        .state     (mc_state)
    );

    // Strict priority. A redirect under a stall is simply retried next cycle
    // because the EX instruction is held; a redirect beats load-use since the
    // ID instruction is wrong-path anyway.
    always_comb begin
        stall_pc      = 1'b0;
        stall_ifid    = 1'b0;
        stall_idex    = 1'b0;
        stall_exmem   = 1'b0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        flush_exmem   = 1'b0;
        flush_memwb   = 1'b0;
        redirect_take = 1'b0;
        if (mem_stall) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
        end else if (mc_stall) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else if (ex_redirect && ex_valid) begin
            flush_ifid    = 1'b1;
            flush_idex    = 1'b1;
            redirect_take = 1'b1;
        end else if (load_use) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
        end
    end

    assign fwd_rs1_sel = fwd_sel(ex_rs1, mem_rd, mem_we, wb_rd, wb_we);
    assign fwd_rs2_sel = fwd_sel(ex_rs2, mem_rd, mem_we, wb_rd, wb_we);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall_pc) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (redirect_take) begin
                redirect_cnt <= sat_inc(redirect_cnt);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit. Four instances share the inputs:
//   0: MC_LAT=3, CNT_W=32   1: MC_LAT=1   2: MC_LAT=2   3: MC_LAT=3, CNT_W=4
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam logic [7:0] CTL_NONE = 8'b0000_0000;
    localparam logic [7:0] CTL_LU   = 8'b1100_0100;
    localparam logic [7:0] CTL_RED  = 8'b0000_1100;
    localparam logic [7:0] CTL_MC   = 8'b1110_0010;
    localparam logic [7:0] CTL_MEM  = 8'b1111_0001;

    logic clk = 1'b0;
    logic rstn;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_rs1_used, id_rs2_used, ex_valid, ex_we, ex_is_load, ex_is_mc;
    logic ex_redirect, mem_we, mem_req, mem_ready, wb_we;

    logic [3:0]  o_spc, o_sif, o_sid, o_sex, o_fif, o_fid, o_fex, o_fmw;
    logic [1:0]  o_f1 [4];
    logic [1:0]  o_f2 [4];
    logic [31:0] o_sc [3];
    logic [31:0] o_rc [3];
    logic [3:0]  sc_c4, rc_c4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(5), .MC_LAT(3), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_we(ex_we),
        .ex_is_load(ex_is_load), .ex_is_mc(ex_is_mc), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .stall_pc(o_spc[0]), .stall_ifid(o_sif[0]), .stall_idex(o_sid[0]), .stall_exmem(o_sex[0]),
        .flush_ifid(o_fif[0]), .flush_idex(o_fid[0]), .flush_exmem(o_fex[0]), .flush_memwb(o_fmw[0]),
        .fwd_rs1_sel(o_f1[0]), .fwd_rs2_sel(o_f2[0]), .stall_cycles(o_sc[0]), .redirect_cnt(o_rc[0])
    );

    hazard_unit #(.REG_AW(5), .MC_LAT(1), .CNT_W(32)) dut_l1 (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_we(ex_we),
        .ex_is_load(ex_is_load), .ex_is_mc(ex_is_mc), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .stall_pc(o_spc[1]), .stall_ifid(o_sif[1]), .stall_idex(o_sid[1]), .stall_exmem(o_sex[1]),
        .flush_ifid(o_fif[1]), .flush_idex(o_fid[1]), .flush_exmem(o_fex[1]), .flush_memwb(o_fmw[1]),
        .fwd_rs1_sel(o_f1[1]), .fwd_rs2_sel(o_f2[1]), .stall_cycles(o_sc[1]), .redirect_cnt(o_rc[1])
    );

    hazard_unit #(.REG_AW(5), .MC_LAT(2), .CNT_W(32)) dut_l2 (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_we(ex_we),
        .ex_is_load(ex_is_load), .ex_is_mc(ex_is_mc), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .stall_pc(o_spc[2]), .stall_ifid(o_sif[2]), .stall_idex(o_sid[2]), .stall_exmem(o_sex[2]),
        .flush_ifid(o_fif[2]), .flush_idex(o_fid[2]), .flush_exmem(o_fex[2]), .flush_memwb(o_fmw[2]),
        .fwd_rs1_sel(o_f1[2]), .fwd_rs2_sel(o_f2[2]), .stall_cycles(o_sc[2]), .redirect_cnt(o_rc[2])
    );

    hazard_unit #(.REG_AW(5), .MC_LAT(3), .CNT_W(4)) dut_c4 (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_we(ex_we),
        .ex_is_load(ex_is_load), .ex_is_mc(ex_is_mc), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .stall_pc(o_spc[3]), .stall_ifid(o_sif[3]), .stall_idex(o_sid[3]), .stall_exmem(o_sex[3]),
        .flush_ifid(o_fif[3]), .flush_idex(o_fid[3]), .flush_exmem(o_fex[3]), .flush_memwb(o_fmw[3]),
        .fwd_rs1_sel(o_f1[3]), .fwd_rs2_sel(o_f2[3]), .stall_cycles(sc_c4), .redirect_cnt(rc_c4)
    );

    function automatic logic [7:0] ctl(input int i);
        return {o_spc[i], o_sif[i], o_sid[i], o_sex[i], o_fif[i], o_fid[i], o_fex[i], o_fmw[i]};
    endfunction

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_valid = 0; ex_we = 0;
        ex_is_load = 0; ex_is_mc = 0; ex_redirect = 0;
        mem_rd = '0; mem_we = 0; mem_req = 0; mem_ready = 0; wb_rd = '0; wb_we = 0;
    endtask

    task automatic idle_cycles(input int n);
        clear_inputs();
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ctl(0) !== CTL_NONE) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl(0), CTL_NONE); end
        checks++; if (o_sc[0] !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0d want 0", o_sc[0]); end
        checks++; if (o_rc[0] !== 32'd0) begin errors++; $display("FAIL reset_redirect_cnt: got %0d want 0", o_rc[0]); end
        checks++; if (dut.u_mc.state !== MC_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.u_mc.state, MC_IDLE); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ex_valid = 1; ex_is_load = 1; ex_we = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        #1;
        checks++; if (ctl(0) !== CTL_LU) begin errors++; $display("FAIL load_use_rs1: got %b want %b", ctl(0), CTL_LU); end
        @(negedge clk);
        checks++; if (o_sc[0] !== 32'd1) begin errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", o_sc[0]); end
        ex_rd = 0; id_rs1 = 0;
        #1;
        checks++; if (ctl(0) !== CTL_NONE) begin errors++; $display("FAIL load_use_x0: got %b want %b", ctl(0), CTL_NONE); end
        @(negedge clk);
        ex_rd = 9; id_rs1 = 3; id_rs2 = 9; id_rs2_used = 1;
        #1;
        checks++; if (ctl(0) !== CTL_LU) begin errors++; $display("FAIL load_use_rs2: got %b want %b", ctl(0), CTL_LU); end
        @(negedge clk);
        id_rs2_used = 0;
        #1;
        checks++; if (ctl(0) !== CTL_NONE) begin errors++; $display("FAIL load_use_unused: got %b want %b", ctl(0), CTL_NONE); end
        @(negedge clk);
        checks++; if (o_sc[0] !== 32'd2) begin errors++; $display("FAIL load_use_stall_cnt2: got %0d want 2", o_sc[0]); end
        idle_cycles(1);
    endtask

    task automatic test_redirect();
        @(negedge clk);
        ex_valid = 1; ex_is_load = 1; ex_we = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1; ex_redirect = 1;
        #1;
        checks++; if (ctl(0) !== CTL_RED) begin errors++; $display("FAIL redirect_over_lu: got %b want %b", ctl(0), CTL_RED); end
        @(negedge clk);
        checks++; if (o_rc[0] !== 32'd1) begin errors++; $display("FAIL redirect_cnt: got %0d want 1", o_rc[0]); end
        checks++; if (o_sc[0] !== 32'd2) begin errors++; $display("FAIL redirect_no_stall_cnt: got %0d want 2", o_sc[0]); end
        ex_valid = 0;
        #1;
        checks++; if (ctl(0) !== CTL_NONE) begin errors++; $display("FAIL redirect_invalid: got %b want %b", ctl(0), CTL_NONE); end
        @(negedge clk);
        checks++; if (o_rc[0] !== 32'd1) begin errors++; $display("FAIL redirect_cnt_hold: got %0d want 1", o_rc[0]); end
        idle_cycles(1);
    endtask

    task automatic test_mc_lat3();
        @(negedge clk);
        ex_valid = 1; ex_is_mc = 1;
        #1;
        checks++; if (ctl(0) !== CTL_MC) begin errors++; $display("FAIL mc3_c1_ctl: got %b want %b", ctl(0), CTL_MC); end
        checks++; if (dut.u_mc.state !== MC_IDLE) begin errors++; $display("FAIL mc3_c1_state: got %0d want %0d", dut.u_mc.state, MC_IDLE); end
        checks++; if (o_spc[1] !== 1'b0) begin errors++; $display("FAIL mc1_c1_stall: got %b want 0", o_spc[1]); end
        @(negedge clk); #1;
        checks++; if (ctl(0) !== CTL_MC) begin errors++; $display("FAIL mc3_c2_ctl: got %b want %b", ctl(0), CTL_MC); end
        checks++; if (dut.u_mc.state !== MC_BUSY) begin errors++; $display("FAIL mc3_c2_state: got %0d want %0d", dut.u_mc.state, MC_BUSY); end
        checks++; if (o_spc[1] !== 1'b0) begin errors++; $display("FAIL mc1_c2_stall: got %b want 0", o_spc[1]); end
        @(negedge clk); #1;
        checks++; if (ctl(0) !== CTL_NONE) begin errors++; $display("FAIL mc3_c3_ctl: got %b want %b", ctl(0), CTL_NONE); end
        checks++; if (dut.u_mc.state !== MC_DONE) begin errors++; $display("FAIL mc3_c3_state: got %0d want %0d", dut.u_mc.state, MC_DONE); end
        checks++; if (o_sc[0] !== 32'd4) begin errors++; $display("FAIL mc3_stall_cnt: got %0d want 4", o_sc[0]); end
        checks++; if (o_sc[1] !== 32'd2) begin errors++; $display("FAIL mc1_stall_cnt: got %0d want 2", o_sc[1]); end
        @(negedge clk);
        ex_valid = 0; ex_is_mc = 0;
        #1;
        checks++; if (dut.u_mc.state !== MC_IDLE) begin errors++; $display("FAIL mc3_c4_state: got %0d want %0d", dut.u_mc.state, MC_IDLE); end
        checks++; if (ctl(0) !== CTL_NONE) begin errors++; $display("FAIL mc3_c4_ctl: got %b want %b", ctl(0), CTL_NONE); end
        idle_cycles(2);
    endtask

    task automatic test_mc_lat2();
        logic [31:0] s0;
        s0 = o_sc[2];
        @(negedge clk);
        ex_valid = 1; ex_is_mc = 1;
        #1;
        checks++; if (ctl(2) !== CTL_MC) begin errors++; $display("FAIL mc2_c1_ctl: got %b want %b", ctl(2), CTL_MC); end
        @(negedge clk); #1;
        checks++; if (ctl(2) !== CTL_NONE) begin errors++; $display("FAIL mc2_c2_ctl: got %b want %b", ctl(2), CTL_NONE); end
        checks++; if (dut_l2.u_mc.state !== MC_DONE) begin errors++; $display("FAIL mc2_c2_state: got %0d want %0d", dut_l2.u_mc.state, MC_DONE); end
        @(negedge clk);
        checks++; if (o_sc[2] !== s0 + 32'd1) begin errors++; $display("FAIL mc2_stall_cnt: got %0d want %0d", o_sc[2], s0 + 32'd1); end
        idle_cycles(3);
    endtask

    task automatic test_mem_wait_done();
        @(negedge clk);
        ex_valid = 1; ex_is_mc = 1;
        repeat (2) @(negedge clk);
        mem_req = 1; mem_ready = 0;
        #1;
        checks++; if (ctl(0) !== CTL_MEM) begin errors++; $display("FAIL memw_c3_ctl: got %b want %b", ctl(0), CTL_MEM); end
        checks++; if (dut.u_mc.state !== MC_DONE) begin errors++; $display("FAIL memw_c3_state: got %0d want %0d", dut.u_mc.state, MC_DONE); end
        @(negedge clk); #1;
        checks++; if (ctl(0) !== CTL_MEM) begin errors++; $display("FAIL memw_c4_ctl: got %b want %b", ctl(0), CTL_MEM); end
        checks++; if (dut.u_mc.state !== MC_DONE) begin errors++; $display("FAIL memw_c4_state: got %0d want %0d", dut.u_mc.state, MC_DONE); end
        @(negedge clk);
        mem_req = 0;
        #1;
        checks++; if (ctl(0) !== CTL_NONE) begin errors++; $display("FAIL memw_noretrig: got %b want %b", ctl(0), CTL_NONE); end
        @(negedge clk);
        ex_valid = 0; ex_is_mc = 0;
        #1;
        checks++; if (dut.u_mc.state !== MC_IDLE) begin errors++; $display("FAIL memw_back_idle: got %0d want %0d", dut.u_mc.state, MC_IDLE); end
        // memory wait in IDLE must defer the start of a new op
        @(negedge clk);
        ex_valid = 1; ex_is_mc = 1; mem_req = 1; mem_ready = 0;
        #1;
        checks++; if (ctl(0) !== CTL_MEM) begin errors++; $display("FAIL memw_idle_ctl: got %b want %b", ctl(0), CTL_MEM); end
        @(negedge clk);
        mem_ready = 1;
        #1;
        checks++; if (dut.u_mc.state !== MC_IDLE) begin errors++; $display("FAIL memw_idle_hold: got %0d want %0d", dut.u_mc.state, MC_IDLE); end
        checks++; if (ctl(0) !== CTL_MC) begin errors++; $display("FAIL memw_release_ctl: got %b want %b", ctl(0), CTL_MC); end
        @(negedge clk);
        idle_cycles(4);
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        ex_rs1 = 7; mem_rd = 7; mem_we = 1; wb_rd = 7; wb_we = 1;
        #1;
        checks++; if (o_f1[0] !== FWD_MEM) begin errors++; $display("FAIL fwd_mem_wins: got %b want %b", o_f1[0], FWD_MEM); end
        mem_we = 0;
        #1;
        checks++; if (o_f1[0] !== FWD_WB) begin errors++; $display("FAIL fwd_wb: got %b want %b", o_f1[0], FWD_WB); end
        wb_we = 0;
        #1;
        checks++; if (o_f1[0] !== FWD_RF) begin errors++; $display("FAIL fwd_rf: got %b want %b", o_f1[0], FWD_RF); end
        ex_rs2 = 0; wb_rd = 0; wb_we = 1; mem_rd = 0; mem_we = 1;
        #1;
        checks++; if (o_f2[0] !== FWD_RF) begin errors++; $display("FAIL fwd_x0: got %b want %b", o_f2[0], FWD_RF); end
        ex_rs2 = 3; wb_rd = 3; mem_rd = 4;
        #1;
        checks++; if (o_f2[0] !== FWD_WB) begin errors++; $display("FAIL fwd_rs2_wb: got %b want %b", o_f2[0], FWD_WB); end
        checks++; if (o_f1[0] !== FWD_RF) begin errors++; $display("FAIL fwd_rs1_indep: got %b want %b", o_f1[0], FWD_RF); end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_mc();
        @(negedge clk);
        ex_valid = 1; ex_is_mc = 1;
        @(negedge clk); #1;
        checks++; if (dut.u_mc.state !== MC_BUSY) begin errors++; $display("FAIL rstmc_busy: got %0d want %0d", dut.u_mc.state, MC_BUSY); end
        #1;
        rstn = 0; ex_valid = 0; ex_is_mc = 0;
        #1;
        checks++; if (dut.u_mc.state !== MC_IDLE) begin errors++; $display("FAIL rstmc_state: got %0d want %0d", dut.u_mc.state, MC_IDLE); end
        checks++; if (o_spc[0] !== 1'b0) begin errors++; $display("FAIL rstmc_stall: got %b want 0", o_spc[0]); end
        checks++; if (o_sc[0] !== 32'd0) begin errors++; $display("FAIL rstmc_sc: got %0d want 0", o_sc[0]); end
        checks++; if (o_rc[0] !== 32'd0) begin errors++; $display("FAIL rstmc_rc: got %0d want 0", o_rc[0]); end
        @(negedge clk);
        rstn = 1;
        @(negedge clk); #1;
        checks++; if (o_sc[0] !== 32'd0) begin errors++; $display("FAIL rstmc_sc_after: got %0d want 0", o_sc[0]); end
        idle_cycles(1);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        mem_req = 1; mem_ready = 0;
        repeat (20) @(negedge clk);
        checks++; if (sc_c4 !== 4'd15) begin errors++; $display("FAIL sat_c4: got %0d want 15", sc_c4); end
        checks++; if (o_sc[0] !== 32'd20) begin errors++; $display("FAIL sat_c32: got %0d want 20", o_sc[0]); end
        idle_cycles(2);
        checks++; if (sc_c4 !== 4'd15) begin errors++; $display("FAIL sat_c4_hold: got %0d want 15", sc_c4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_mc_lat3();
        test_mc_lat2();
        test_mem_wait_done();
        test_forwarding();
        test_reset_mid_mc();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
